merge_ctrl: RTL and testbench

MERGE_CTRL -- requirements
Module: merge_ctrl

---
 rtl/merge_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_merge_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : merge_ctrl
//  Description : Frame controller between a UART byte receiver and a sample
//                merge datapath. Hunts for a two-byte header (SYNC_A, SYNC_B),
//                latches a sample count N, forwards N*BPS payload bytes to the
//                merge datapath one cycle after reception, counts merged
//                samples handed to the demodulator and reports frame
//                completion or frame errors (zero length, timeout, overrun).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              : single clock, rising edge
//    rst              : synchronous active-high reset
//    uart_valid_i     : one-cycle strobe, uart_data_i holds a received byte
//    uart_data_i[7:0] : received UART byte
//    merge_finished_i : merge datapath completed one 2*WIDTH sample
//    demod_ready_i    : demodulator can accept a sample this cycle
//    merge_en_o       : consume merge_byte_o this cycle
//    merge_byte_o[7:0]: payload byte forwarded to the merge datapath
//    sample_valid_o   : merged sample presented to the demodulator
//    frame_active_o   : frame in progress (LEN, STREAM, DRAIN)
//    frame_done_o     : one-cycle pulse on normal frame completion
//    err_o            : one-cycle pulse on a frame error
//    err_code_o[1:0]  : last error cause (01 zero len, 10 timeout, 11 overrun)
// ============================================================================
module merge_ctrl #(
    parameter int         WIDTH   = 16,
    parameter logic [7:0] SYNC_A  = 8'hA5,
    parameter logic [7:0] SYNC_B  = 8'h5A,
    parameter int         TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_valid_i,
    input  logic [7:0] uart_data_i,
    input  logic       merge_finished_i,
    input  logic       demod_ready_i,
    output logic       merge_en_o,
    output logic [7:0] merge_byte_o,
    output logic       sample_valid_o,
    output logic       frame_active_o,
    output logic       frame_done_o,
    output logic       err_o,
    output logic [1:0] err_code_o
);

    // Bytes per merged sample.
    localparam int c_BPS = (2 * WIDTH) / 8;

    // Idle counter only has to reach TIMEOUT-1 before the frame is aborted.
    localparam int                  c_IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SYNC2  = 3'd1;
    localparam logic [2:0] c_ST_LEN    = 3'd2;
    localparam logic [2:0] c_ST_STREAM = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    localparam logic [1:0] c_ERR_ZERO    = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] c_ERR_OVERRUN = 2'b11;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]          state_q,      state_d;
    logic [7:0]          len_q,        len_d;
    logic [15:0]         byte_cnt_q,   byte_cnt_d;
    logic [7:0]          sample_cnt_q, sample_cnt_d;
    logic [c_IDLE_W-1:0] idle_cnt_q,   idle_cnt_d;
    logic                merge_en_q,   merge_en_d;
    logic [7:0]          merge_byte_q, merge_byte_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q,        err_d;
    logic [1:0]          err_code_q,   err_code_d;

    // ------------------------------------------------------------------------
    // Decoded conditions
    // ------------------------------------------------------------------------
    logic        w_in_stream;
    logic        w_in_data;
    logic        w_active;
    logic        w_activity;
    logic        w_finish;
    logic        w_overrun;
    logic        w_timeout;
    logic [15:0] w_frame_bytes;
    logic        w_stream_full;
    logic        w_forward;
    logic [8:0]  w_sample_sum;
    logic        w_drain_done;
    logic        w_len_load;

    assign w_in_stream   = (state_q == c_ST_STREAM);
    assign w_in_data     = w_in_stream || (state_q == c_ST_DRAIN);
    assign w_active      = w_in_data || (state_q == c_ST_LEN);
    assign w_activity    = uart_valid_i || merge_finished_i;

    // Merged samples are only meaningful while payload is in flight.
    assign w_finish      = merge_finished_i && w_in_data;
    assign w_overrun     = w_finish && !demod_ready_i;
    assign w_timeout     = w_active && !w_activity && (idle_cnt_q == c_IDLE_LAST);

    assign w_frame_bytes = 16'(len_q) * 16'(c_BPS);
    assign w_stream_full = (byte_cnt_q == w_frame_bytes);

    // STREAM stays one more cycle after the final byte is captured so that
    // its merge_en_o pulse is still issued from within STREAM; any byte that
    // arrives once the payload is complete is dropped.
    assign w_forward     = w_in_stream && uart_valid_i && !w_stream_full;

    // Sample count including a completion arriving this very cycle.
    assign w_sample_sum  = {1'b0, sample_cnt_q} + {8'd0, w_finish};
    assign w_drain_done  = (state_q == c_ST_DRAIN) && (w_sample_sum >= {1'b0, len_q});

    assign w_len_load    = (state_q == c_ST_LEN) && uart_valid_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_ST_IDLE;
            len_q        <= 8'd0;
            byte_cnt_q   <= 16'd0;
            sample_cnt_q <= 8'd0;
            idle_cnt_q   <= '0;
            merge_en_q   <= 1'b0;
            merge_byte_q <= 8'd0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            merge_en_q   <= merge_en_d;
            merge_byte_q <= merge_byte_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (uart_valid_i && (uart_data_i == SYNC_A)) begin
                    state_d = c_ST_SYNC2;
                end
            end
            c_ST_SYNC2: begin
                if (uart_valid_i) begin
                    if (uart_data_i == SYNC_B) begin
                        state_d = c_ST_LEN;
                    end else if (uart_data_i == SYNC_A) begin
                        // A repeated first header byte may still start a header.
                        state_d = c_ST_SYNC2;
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end
            end
            c_ST_LEN: begin
                if (uart_valid_i) begin
                    state_d = (uart_data_i == 8'd0) ? c_ST_IDLE : c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (w_stream_full) begin
                    state_d = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_done) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        // Abort conditions override every regular transition.
        if (w_overrun || w_timeout) begin
            state_d = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Counters, forwarded byte and status pulses
    // ------------------------------------------------------------------------
    always_comb begin
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        sample_cnt_d = sample_cnt_q;
        idle_cnt_d   = '0;
        merge_en_d   = 1'b0;
        merge_byte_d = merge_byte_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        // Counters are reloaded only here; errors leave them untouched.
        if (w_len_load) begin
            len_d        = uart_data_i;
            byte_cnt_d   = 16'd0;
            sample_cnt_d = 8'd0;
            if (uart_data_i == 8'd0) begin
                err_d      = 1'b1;
                err_code_d = c_ERR_ZERO;
            end
        end

        if (w_forward) begin
            merge_en_d   = 1'b1;
            merge_byte_d = uart_data_i;
            byte_cnt_d   = byte_cnt_q + 16'd1;
        end

        if (w_finish) begin
            sample_cnt_d = w_sample_sum[7:0];
        end

        if (w_active && !w_activity) begin
            idle_cnt_d = idle_cnt_q + c_IDLE_ONE;
        end

        // Overrun takes precedence over a completion in the same cycle.
        if (w_overrun) begin
            err_d      = 1'b1;
            err_code_d = c_ERR_OVERRUN;
        end else if (w_timeout) begin
            err_d      = 1'b1;
            err_code_d = c_ERR_TIMEOUT;
        end else if (w_drain_done) begin
            frame_done_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: forced low for the whole time reset is held, including the
    // first reset cycle before the registers have cleared.
    // ------------------------------------------------------------------------
    always_comb begin
        merge_en_o     = merge_en_q && !rst;
        merge_byte_o   = rst ? 8'd0 : merge_byte_q;
        sample_valid_o = w_finish && !rst;
        frame_active_o = w_active && !rst;
        frame_done_o   = frame_done_q && !rst;
        err_o          = err_q && !rst;
        err_code_o     = rst ? 2'b00 : err_code_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_merge_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_merge_ctrl
//  Description : Self-checking bench for merge_ctrl. Frames are generated at
//                transaction level; the expected merge_en_o bytes,
//                sample_valid_o strobes and done/error events are queued as
//                stimulus is issued and a monitor pops them as the DUT
//                presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_ctrl;

    localparam int         WIDTH = 16;
    localparam int         BPS   = (2 * WIDTH) / 8;
    localparam int         TO    = 64;
    localparam logic [7:0] SA    = 8'hA5;
    localparam logic [7:0] SB    = 8'h5A;

    localparam int M_NORMAL  = 0;
    localparam int M_OVERRUN = 1;
    localparam int M_TIMEOUT = 2;
    localparam int M_RESET   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_valid_i = 1'b0;
    logic [7:0] uart_data_i = 8'd0;
    logic       merge_finished_i = 1'b0;
    logic       demod_ready_i = 1'b1;
    logic       merge_en_o;
    logic [7:0] merge_byte_o;
    logic       sample_valid_o;
    logic       frame_active_o;
    logic       frame_done_o;
    logic       err_o;
    logic [1:0] err_code_o;

    merge_ctrl #(
        .WIDTH   (WIDTH),
        .SYNC_A  (SA),
        .SYNC_B  (SB),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_valid_i     (uart_valid_i),
        .uart_data_i      (uart_data_i),
        .merge_finished_i (merge_finished_i),
        .demod_ready_i    (demod_ready_i),
        .merge_en_o       (merge_en_o),
        .merge_byte_o     (merge_byte_o),
        .sample_valid_o   (sample_valid_o),
        .frame_active_o   (frame_active_o),
        .frame_done_o     (frame_done_o),
        .err_o            (err_o),
        .err_code_o       (err_code_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } byte_exp_t;

    typedef struct {
        int         kind;   // 0 = frame_done, 1 = err
        logic [1:0] code;
        int         cyc;    // -1 when only the order matters
    } ev_t;

    byte_exp_t  byte_q[$];
    int         sv_q[$];
    ev_t        ev_q[$];
    logic [7:0] pre_in[$];

    int n_checks = 0;
    int n_errors = 0;
    int last_act = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    byte_exp_t m_b;
    int        m_s;
    ev_t       m_e;

    always @(negedge clk) begin
        if (byte_q.size() > 0 && byte_q[0].cyc < cyc) begin
            chk("merge_en_missing", byte_q[0].cyc, cyc);
            m_b = byte_q.pop_front();
        end
        if (merge_en_o) begin
            if (byte_q.size() == 0) begin
                chk("merge_en_unexpected", merge_en_o, 0);
            end else begin
                m_b = byte_q.pop_front();
                chk("merge_en_cycle", cyc, m_b.cyc);
                chk("merge_byte", merge_byte_o, m_b.data);
            end
        end

        if (sv_q.size() > 0 && sv_q[0] < cyc) begin
            chk("sample_valid_missing", sv_q[0], cyc);
            m_s = sv_q.pop_front();
        end
        if (sample_valid_o) begin
            if (sv_q.size() == 0) begin
                chk("sample_valid_unexpected", sample_valid_o, 0);
            end else begin
                m_s = sv_q.pop_front();
                chk("sample_valid_cycle", cyc, m_s);
            end
        end

        if (ev_q.size() > 0 && ev_q[0].cyc >= 0 && ev_q[0].cyc < cyc) begin
            chk("event_missing", ev_q[0].cyc, cyc);
            m_e = ev_q.pop_front();
        end
        if (frame_done_o) begin
            if (ev_q.size() == 0) begin
                chk("frame_done_unexpected", frame_done_o, 0);
            end else begin
                m_e = ev_q.pop_front();
                chk("event_kind_done", 0, m_e.kind);
                if (m_e.cyc >= 0) chk("done_cycle", cyc, m_e.cyc);
            end
        end
        if (err_o) begin
            if (ev_q.size() == 0) begin
                chk("err_unexpected", err_o, 0);
            end else begin
                m_e = ev_q.pop_front();
                chk("event_kind_err", 1, m_e.kind);
                chk("err_code", err_code_o, m_e.code);
                if (m_e.cyc >= 0) chk("err_cycle", cyc, m_e.cyc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_valid_i     = 1'b0;
        merge_finished_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic gap();
        idle($urandom_range(0, 2));
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit fwd);
        byte_exp_t e;
        uart_valid_i = 1'b1;
        uart_data_i  = b;
        if (fwd) begin
            e.cyc  = cyc + 1;
            e.data = b;
            byte_q.push_back(e);
        end
        last_act = cyc;
        step();
        uart_valid_i = 1'b0;
    endtask

    task automatic drive_finish(input bit ready);
        merge_finished_i = 1'b1;
        demod_ready_i    = ready;
        sv_q.push_back(cyc);
        last_act = cyc;
        step();
        merge_finished_i = 1'b0;
        demod_ready_i    = 1'b1;
    endtask

    task automatic push_ev(input int kind, input logic [1:0] code, input int when);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.cyc  = when;
        ev_q.push_back(e);
    endtask

    // Reference rule for header hunting: the length byte follows the first
    // adjacent SYNC_A,SYNC_B pair in the received byte stream.
    function automatic int len_index(input logic [7:0] s[$]);
        for (int i = 0; i + 1 < s.size(); i++) begin
            if (s[i] == SA && s[i+1] == SB) return i + 2;
        end
        return s.size() - 1;
    endfunction

    // ------------------------------------------------------------------------
    // One frame: prefix bytes (pre_in), header, length n, payload.
    // ------------------------------------------------------------------------
    task automatic run_frame(input int n, input int mode, input int stop_at);
        logic [7:0] s[$];
        int idx, mlen, total, grp;
        s = pre_in;
        s.push_back(SA);
        s.push_back(SB);
        s.push_back(8'(n));
        idx   = len_index(s);
        mlen  = int'(s[idx]);
        total = mlen * BPS;

        chk("idle_before_frame", frame_active_o, 0);
        foreach (s[k]) begin
            if (k == idx && mlen == 0) push_ev(1, 2'b01, cyc + 1);
            drive_byte(s[k], 1'b0);
            if (k != idx) gap();
        end

        if (mlen == 0) begin
            idle(3);
            chk("zero_len_active", frame_active_o, 0);
            chk("zero_len_code", err_code_o, 1);
        end else begin
            gap();
            chk("frame_active_in_frame", frame_active_o, 1);
            for (int i = 0; i < total; i++) begin
                if ((mode == M_TIMEOUT || mode == M_RESET) && i == stop_at) break;
                drive_byte(8'($urandom_range(0, 255)), 1'b1);
                if ((i + 1) % BPS == 0) begin
                    grp = (i + 1) / BPS - 1;
                    gap();
                    if (mode == M_OVERRUN && grp == stop_at) begin
                        push_ev(1, 2'b11, cyc + 1);
                        drive_finish(1'b0);
                        break;
                    end
                    if (grp == mlen - 1) begin
                        // Bytes beyond the payload must not be forwarded.
                        if ($urandom_range(0, 1) == 1) drive_byte(8'($urandom_range(0, 255)), 1'b0);
                        push_ev(0, 2'b00, -1);
                    end
                    drive_finish(1'b1);
                end
                gap();
            end

            case (mode)
                M_OVERRUN: begin
                    idle(3);
                    chk("overrun_active", frame_active_o, 0);
                    chk("overrun_code_held", err_code_o, 3);
                end
                M_TIMEOUT: begin
                    push_ev(1, 2'b10, last_act + TO + 1);
                    idle(TO + 3);
                    chk("timeout_active", frame_active_o, 0);
                    chk("timeout_code_held", err_code_o, 2);
                end
                M_RESET: begin
                    idle(2);
                    rst = 1'b1;
                    step();
                    chk("rst_merge_en", merge_en_o, 0);
                    chk("rst_active", frame_active_o, 0);
                    chk("rst_err", err_o, 0);
                    chk("rst_done", frame_done_o, 0);
                    step();
                    chk("rst_code", err_code_o, 0);
                    rst = 1'b0;
                    idle(3);
                    chk("after_rst_active", frame_active_o, 0);
                end
                default: begin
                    idle(4);
                    chk("done_active", frame_active_o, 0);
                end
            endcase
        end

        chk("byte_q_left", byte_q.size(), 0);
        chk("sv_q_left", sv_q.size(), 0);
        chk("ev_q_left", ev_q.size(), 0);
        byte_q.delete();
        sv_q.delete();
        ev_q.delete();
        idle(2);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int mode, n, stop, np;
        logic [7:0] b;

        // Reset with busy inputs: every output must stay low.
        rst              = 1'b1;
        uart_valid_i     = 1'b1;
        uart_data_i      = SA;
        merge_finished_i = 1'b1;
        step();
        repeat (3) begin
            chk("reset_merge_en", merge_en_o, 0);
            chk("reset_merge_byte", merge_byte_o, 0);
            chk("reset_sample_valid", sample_valid_o, 0);
            chk("reset_active", frame_active_o, 0);
            chk("reset_done", frame_done_o, 0);
            chk("reset_err", err_o, 0);
            chk("reset_err_code", err_code_o, 0);
            step();
        end
        uart_valid_i     = 1'b0;
        merge_finished_i = 1'b0;
        rst              = 1'b0;
        idle(2);

        // Directed frames.
        pre_in = {};
        run_frame(2, M_NORMAL, 0);
        pre_in = {8'h11, 8'hA5};
        run_frame(1, M_NORMAL, 0);
        pre_in = {};
        run_frame(0, M_NORMAL, 0);
        run_frame(1, M_OVERRUN, 0);
        run_frame(2, M_TIMEOUT, 3);
        run_frame(2, M_RESET, 5);
        run_frame(1, M_NORMAL, 0);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            pre_in = {};
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SB) b = 8'h00;
                pre_in.push_back(b);
            end
            mode = $urandom_range(0, 9);
            n    = $urandom_range(1, 4);
            stop = 0;
            if (mode == 9) begin
                n    = 0;
                mode = M_NORMAL;
            end else if (mode <= 5) begin
                mode = M_NORMAL;
            end else if (mode == 6) begin
                mode = M_OVERRUN;
                stop = $urandom_range(0, n - 1);
            end else if (mode == 7) begin
                mode = M_TIMEOUT;
                stop = $urandom_range(1, n * BPS - 1);
            end else begin
                mode = M_RESET;
                stop = $urandom_range(1, n * BPS - 1);
            end
            run_frame(n, mode, stop);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
